unidade_de_busca: RTL and testbench
===================================

UNIDADE_DE_BUSCA -- requirements
Module: unidade_de_busca

Interface
REQ-001 Parameter PC_INICIAL, default 8'h00: PC value loaded on reset.
REQ-002 Parameter LARGURA, default 8: instruction and PC width in bits; only 8 is supported.
REQ-003 clock  input  1  sole clock; all state updates on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 imem_addr  output  8  instruction memory address; equals PC.
REQ-006 imem_req  output  1  fetch request to instruction memory.
REQ-007 imem_ack  input  1  memory accepts the request and returns valid imem_data in the same cycle.
REQ-008 imem_data  input  8  instruction word: [7:5] opcode, [4:0] immediate.
REQ-009 opcode  output  3  opcode presented to unidade_de_controle.
REQ-010 imediato  output  5  immediate field of the issued instruction.
REQ-011 instr_valida  output  1  opcode/imediato are valid this cycle.
REQ-012 PCWrite  input  1  control unit permits a PC update.
REQ-013 Jump  input  1  absolute jump request.
REQ-014 BEQ  input  1  conditional branch request.
REQ-015 zero  input  1  ULA zero flag.
REQ-016 jump_addr  input  8  absolute jump target.
REQ-017 pc  output  8  current PC.

Function
REQ-018 The FSM SHALL have the states BUSCA, EMITE and ATUALIZA.
REQ-019 BUSCA: imem_req=1 and imem_addr=PC; on imem_ack=1, latch imem_data into the instruction register and go to EMITE; with imem_ack=0, remain in BUSCA and hold imem_addr stable.
REQ-020 EMITE: instr_valida=1 and opcode/imediato driven from the instruction register; wait here until PCWrite=1, then latch Jump/BEQ/zero/jump_addr and go to ATUALIZA.
REQ-021 ATUALIZA: update PC once, then go to BUSCA; instr_valida=0 and imem_req=0.
REQ-022 Next-PC priority: Jump=1 -> jump_addr; else BEQ=1 and zero=1 -> PC + sign_extend(imediato); else PC + 1.
REQ-023 All PC arithmetic SHALL be modulo 256 (8'hFF+1=8'h00; 8'h02+5'h1C(-4)=8'hFE).
REQ-024 Jump and BEQ both 1: Jump wins.
REQ-025 BEQ=1 with zero=0: sequential PC+1.
REQ-026 Minimum latency: 3 cycles per instruction (BUSCA with immediate ack, EMITE with PCWrite, ATUALIZA).
REQ-027 Inputs PCWrite/Jump/BEQ/zero/jump_addr SHALL be ignored outside EMITE.
REQ-028 imem_ack outside BUSCA SHALL be ignored.
REQ-029 The instruction register SHALL hold its value between fetches; opcode/imediato are stable for the entire time in EMITE.

Reset
REQ-030 reset=1 at a clock edge SHALL force state=BUSCA, PC=PC_INICIAL, instruction register=8'h00, from any state, including mid-fetch or mid-issue.
REQ-031 While reset=1: imem_req=0, instr_valida=0, opcode=3'b000, imediato=5'b00000, pc=PC_INICIAL.
REQ-032 First fetch: imem_req=1 with imem_addr=PC_INICIAL in the first cycle after reset deasserts.
REQ-033 reset has priority over every other input in the same cycle.

Structure
REQ-034 The state encoding, opcode field positions [7:5]/[4:0] and PC width SHALL be defined in a shared package also used by unidade_de_controle.
REQ-035 The next-PC computation SHALL be a separate combinational sub-module calculo_prox_pc (PC, imediato, jump_addr, Jump, BEQ, zero -> prox_pc).
REQ-036 The block contains exactly three registers: state, PC and instruction register.

Verification
REQ-037 Reset then imem_ack=1 always, data 8'h25, PCWrite=1, Jump=BEQ=0 -> opcode=3'b001, imediato=5'h05, PC 00->01 after 3 cycles.
REQ-038 PC=8'h10, data 8'hC3, BEQ=1, zero=1, PCWrite=1 -> PC=8'h13; repeat with zero=0 -> PC=8'h11.
REQ-039 PC=8'h02, imediato=5'h1C, BEQ=1, zero=1 -> PC=8'hFE (negative offset); PC=8'hFF sequential -> PC=8'h00.
REQ-040 Jump=1 and BEQ=1, zero=1, jump_addr=8'h40 -> PC=8'h40.
REQ-041 imem_ack held 0 for 4 cycles -> imem_req=1, imem_addr constant, instr_valida=0; PCWrite held 0 for 3 cycles in EMITE -> PC unchanged, opcode stable.
REQ-042 reset asserted in EMITE with PCWrite=1 -> next cycle PC=PC_INICIAL, instr_valida=0, state BUSCA.

Source files
------------

// File: rtl/unidade_de_busca_pkg.sv
// Shared definitions for the fetch unit and the control unit: PC width,
// instruction field layout and FSM state encoding.
package unidade_de_busca_pkg;

  localparam int unsigned LARGURA_PC       = 8;
  localparam int unsigned LARGURA_OPCODE   = 3;
  localparam int unsigned LARGURA_IMEDIATO = 5;

  typedef enum logic [1:0] {
    BUSCA    = 2'b00,
    EMITE    = 2'b01,
    ATUALIZA = 2'b10
  } estado_t;

  // Instruction word: opcode in [7:5], immediate in [4:0]
  typedef struct packed {
    logic [LARGURA_OPCODE-1:0]   opcode;
    logic [LARGURA_IMEDIATO-1:0] imediato;
  } instrucao_t;

  // Two's-complement extension of the branch immediate to PC width
  function automatic logic [LARGURA_PC-1:0] estende_sinal(input logic [LARGURA_IMEDIATO-1:0] imm);
    return {{(LARGURA_PC - LARGURA_IMEDIATO){imm[LARGURA_IMEDIATO-1]}}, imm};
  endfunction

endpackage

// File: rtl/unidade_de_busca_if.sv
// Instruction memory bus: request/address out, ack/data back in the same cycle.
interface unidade_de_busca_if;
  import unidade_de_busca_pkg::*;

  logic [LARGURA_PC-1:0] imem_addr;
  logic                  imem_req;
  logic                  imem_ack;
  instrucao_t            imem_data;

  modport master (output imem_addr, imem_req, input imem_ack, imem_data);
  modport slave  (input imem_addr, imem_req, output imem_ack, imem_data);

endinterface

// File: rtl/unidade_de_busca_calculo_prox_pc.sv
// Next-PC selection: absolute jump, taken branch, or sequential, all modulo 2^8.
module calculo_prox_pc
  import unidade_de_busca_pkg::*;
(
  input  logic [LARGURA_PC-1:0]       pc,
  input  logic [LARGURA_IMEDIATO-1:0] imediato,
  input  logic [LARGURA_PC-1:0]       jump_addr,
  input  logic                        Jump,
  input  logic                        BEQ,
  input  logic                        zero,
  output logic [LARGURA_PC-1:0]       prox_pc
);

  // Jump has priority over a taken branch; otherwise fall through
  always_comb begin
    prox_pc = pc + LARGURA_PC'(1);
    if (Jump) begin
      prox_pc = jump_addr;
    end else if (BEQ && zero) begin
      prox_pc = pc + estende_sinal(imediato);
    end
  end

endmodule

// File: rtl/unidade_de_busca.sv
// Instruction fetch unit: fetches one word, issues it to the control unit,
// then advances the PC according to the control unit's decision.
module unidade_de_busca
  import unidade_de_busca_pkg::*;
#(
  parameter logic [7:0]  PC_INICIAL = 8'h00,
  parameter int unsigned LARGURA    = 8
) (
  input  logic                        clock,
  input  logic                        reset,
  unidade_de_busca_if.master          imem,
  output logic [LARGURA_OPCODE-1:0]   opcode,
  output logic [LARGURA_IMEDIATO-1:0] imediato,
  output logic                        instr_valida,
  input  logic                        PCWrite,
  input  logic                        Jump,
  input  logic                        BEQ,
  input  logic                        zero,
  input  logic [LARGURA_PC-1:0]       jump_addr,
  output logic [LARGURA-1:0]          pc
);

  estado_t               estado;
  estado_t               estado_prox;
  logic [LARGURA-1:0]    pc_q;
  instrucao_t            ir_q;
  logic                  carrega_ir;
  logic                  carrega_pc;
  logic [LARGURA_PC-1:0] prox_pc;

  calculo_prox_pc u_calculo_prox_pc (
    .pc        (LARGURA_PC'(pc_q)),
    .imediato  (ir_q.imediato),
    .jump_addr (jump_addr),
    .Jump      (Jump),
    .BEQ       (BEQ),
    .zero      (zero),
    .prox_pc   (prox_pc)
  );

  // State, PC and instruction registers; reset wins over everything
  always_ff @(posedge clock) begin
    if (reset) begin
      estado <= BUSCA;
      pc_q   <= LARGURA'(PC_INICIAL);
      ir_q   <= '0;
    end else begin
      estado <= estado_prox;
      if (carrega_ir) begin
        ir_q <= imem.imem_data;
      end
      // Control inputs are only valid in EMITE, so the resolved target is
      // committed on the EMITE->ATUALIZA edge; ATUALIZA is the settle cycle.
      if (carrega_pc) begin
        pc_q <= LARGURA'(prox_pc);
      end
    end
  end

  // Next-state and register load enables
  always_comb begin
    estado_prox = estado;
    carrega_ir  = 1'b0;
    carrega_pc  = 1'b0;
    case (estado)
      BUSCA: begin
        if (imem.imem_ack) begin
          carrega_ir  = 1'b1;
          estado_prox = EMITE;
        end
      end
      EMITE: begin
        if (PCWrite) begin
          carrega_pc  = 1'b1;
          estado_prox = ATUALIZA;
        end
      end
      ATUALIZA: begin
        estado_prox = BUSCA;
      end
      default: begin
        estado_prox = BUSCA;
      end
    endcase
  end

  // Output decode; reset masks everything to its idle value combinationally
  always_comb begin
    pc            = pc_q;
    opcode        = ir_q.opcode;
    imediato      = ir_q.imediato;
    instr_valida  = (estado == EMITE);
    imem.imem_req = (estado == BUSCA);
    if (reset) begin
      pc            = LARGURA'(PC_INICIAL);
      opcode        = '0;
      imediato      = '0;
      instr_valida  = 1'b0;
      imem.imem_req = 1'b0;
    end
    imem.imem_addr = LARGURA_PC'(pc);
  end

endmodule

// File: tb/tb_unidade_de_busca.sv
// Scoreboard bench for unidade_de_busca: fetched words and next-PC targets
// are predicted when driven and checked when the DUT presents them.
module tb_unidade_de_busca;

  localparam logic [7:0] PC_INI = 8'h00;

  logic       clock;
  logic       reset;
  logic       PCWrite;
  logic       Jump;
  logic       BEQ;
  logic       zero;
  logic [7:0] jump_addr;
  logic [2:0] opcode;
  logic [4:0] imediato;
  logic       instr_valida;
  logic [7:0] pc;

  unidade_de_busca_if mem_if ();

  unidade_de_busca #(.PC_INICIAL(PC_INI), .LARGURA(8)) dut (
    .clock        (clock),
    .reset        (reset),
    .imem         (mem_if.master),
    .opcode       (opcode),
    .imediato     (imediato),
    .instr_valida (instr_valida),
    .PCWrite      (PCWrite),
    .Jump         (Jump),
    .BEQ          (BEQ),
    .zero         (zero),
    .jump_addr    (jump_addr),
    .pc           (pc)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int         n_comp = 0;
  int         n_erro = 0;
  logic [7:0] model_pc;
  logic [7:0] q_instr[$];
  logic [7:0] q_pc[$];

  task automatic confere(input string tag, input logic [31:0] obs, input logic [31:0] esp);
    n_comp++;
    if (obs !== esp) begin
      n_erro++;
      $display("FAIL %s: obtido %0h esperado %0h", tag, obs, esp);
    end
  endtask

  // Reference next-PC using signed integer arithmetic
  function automatic logic [7:0] prox_modelo(input logic [7:0] p, input logic [4:0] imm,
                                             input logic j, input logic b, input logic z,
                                             input logic [7:0] ja);
    int s;
    if (j) return ja;
    if (b && z) begin
      s = imm[4] ? int'(imm) - 32 : int'(imm);
      return 8'((int'(p) + s + 256) % 256);
    end
    return 8'((int'(p) + 1) % 256);
  endfunction

  task automatic ciclo();
    @(posedge clock);
    #1;
  endtask

  // One full instruction: optional ack stall, issue with optional PCWrite stall, update
  task automatic executa(input logic [7:0] dado, input int esp_ack, input int esp_pcw,
                         input logic j, input logic b, input logic z, input logic [7:0] ja);
    logic [7:0] exp_ins;
    logic [7:0] exp_pc;
    confere("busca_req", 32'(mem_if.imem_req), 32'd1);
    confere("busca_addr", 32'(mem_if.imem_addr), 32'(model_pc));
    confere("busca_valida", 32'(instr_valida), 32'd0);
    for (int i = 0; i < esp_ack; i++) begin
      mem_if.imem_ack  = 1'b0;
      mem_if.imem_data = 8'($urandom);
      PCWrite = 1'b1; Jump = 1'b1; jump_addr = 8'($urandom);
      ciclo();
      confere("espera_req", 32'(mem_if.imem_req), 32'd1);
      confere("espera_addr", 32'(mem_if.imem_addr), 32'(model_pc));
      confere("espera_valida", 32'(instr_valida), 32'd0);
    end
    mem_if.imem_ack  = 1'b1;
    mem_if.imem_data = dado;
    PCWrite = 1'b1; Jump = 1'b1; jump_addr = 8'($urandom);
    q_instr.push_back(dado);
    ciclo();
    mem_if.imem_ack  = 1'b1;
    mem_if.imem_data = ~dado;
    if (q_instr.size() == 0) begin
      confere("fila_instr_vazia", 32'd0, 32'd1);
      exp_ins = 8'h00;
    end else begin
      exp_ins = q_instr.pop_front();
    end
    confere("emite_valida", 32'(instr_valida), 32'd1);
    confere("emite_opcode", 32'(opcode), 32'(exp_ins[7:5]));
    confere("emite_imediato", 32'(imediato), 32'(exp_ins[4:0]));
    for (int i = 0; i < esp_pcw; i++) begin
      PCWrite = 1'b0; Jump = 1'b1; BEQ = 1'b1; zero = 1'b1; jump_addr = 8'($urandom);
      ciclo();
      confere("pcw_valida", 32'(instr_valida), 32'd1);
      confere("pcw_opcode", 32'(opcode), 32'(exp_ins[7:5]));
      confere("pcw_imediato", 32'(imediato), 32'(exp_ins[4:0]));
      confere("pcw_pc", 32'(pc), 32'(model_pc));
    end
    PCWrite = 1'b1; Jump = j; BEQ = b; zero = z; jump_addr = ja;
    q_pc.push_back(prox_modelo(model_pc, exp_ins[4:0], j, b, z, ja));
    ciclo();
    PCWrite = 1'b1; Jump = 1'b1; BEQ = 1'b1; zero = 1'b1; jump_addr = 8'($urandom);
    mem_if.imem_ack = 1'b1;
    confere("atualiza_valida", 32'(instr_valida), 32'd0);
    confere("atualiza_req", 32'(mem_if.imem_req), 32'd0);
    ciclo();
    mem_if.imem_ack = 1'b0;
    PCWrite = 1'b0; Jump = 1'b0; BEQ = 1'b0; zero = 1'b0;
    if (q_pc.size() == 0) begin
      confere("fila_pc_vazia", 32'd0, 32'd1);
      exp_pc = model_pc;
    end else begin
      exp_pc = q_pc.pop_front();
    end
    confere("novo_pc", 32'(pc), 32'(exp_pc));
    confere("novo_addr", 32'(mem_if.imem_addr), 32'(exp_pc));
    confere("novo_req", 32'(mem_if.imem_req), 32'd1);
    model_pc = exp_pc;
  endtask

  initial begin
    reset = 1'b1;
    PCWrite = 1'b1; Jump = 1'b1; BEQ = 1'b0; zero = 1'b0; jump_addr = 8'h55;
    mem_if.imem_ack  = 1'b1;
    mem_if.imem_data = 8'hFF;
    ciclo();
    ciclo();
    confere("rst_req", 32'(mem_if.imem_req), 32'd0);
    confere("rst_valida", 32'(instr_valida), 32'd0);
    confere("rst_opcode", 32'(opcode), 32'd0);
    confere("rst_imediato", 32'(imediato), 32'd0);
    confere("rst_pc", 32'(pc), 32'(PC_INI));
    reset = 1'b0;
    mem_if.imem_ack = 1'b0;
    PCWrite = 1'b0; Jump = 1'b0;
    #1;
    model_pc = PC_INI;

    // Sequential fetch of 8'h25
    executa(8'h25, 0, 0, 1'b0, 1'b0, 1'b0, 8'h00);
    // Taken and not-taken branch from 8'h10
    executa(8'h00, 0, 0, 1'b1, 1'b0, 1'b0, 8'h10);
    executa(8'hC3, 0, 0, 1'b0, 1'b1, 1'b1, 8'h00);
    executa(8'h00, 0, 0, 1'b1, 1'b0, 1'b0, 8'h10);
    executa(8'hC3, 0, 0, 1'b0, 1'b1, 1'b0, 8'h00);
    // Negative offset wrap and sequential wrap
    executa(8'h00, 0, 0, 1'b1, 1'b0, 1'b0, 8'h02);
    executa(8'h9C, 0, 0, 1'b0, 1'b1, 1'b1, 8'h00);
    executa(8'h00, 0, 0, 1'b1, 1'b0, 1'b0, 8'hFF);
    executa(8'h11, 0, 0, 1'b0, 1'b0, 1'b0, 8'h00);
    // Jump beats taken branch
    executa(8'hC3, 0, 0, 1'b1, 1'b1, 1'b1, 8'h40);
    // Memory stall and control-unit stall
    executa(8'h6A, 4, 3, 1'b0, 1'b0, 1'b0, 8'h00);
    // Random traffic
    for (int k = 0; k < 8; k++) begin
      executa(8'($urandom), int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
              1'($urandom), 1'($urandom), 1'($urandom), 8'($urandom));
    end

    // Reset while issuing with PCWrite asserted
    mem_if.imem_ack  = 1'b1;
    mem_if.imem_data = 8'hA7;
    ciclo();
    mem_if.imem_ack = 1'b0;
    confere("pre_rst_valida", 32'(instr_valida), 32'd1);
    confere("pre_rst_opcode", 32'(opcode), 32'h5);
    PCWrite = 1'b1; Jump = 1'b1; jump_addr = 8'h77; reset = 1'b1;
    ciclo();
    confere("mid_rst_pc", 32'(pc), 32'(PC_INI));
    confere("mid_rst_valida", 32'(instr_valida), 32'd0);
    confere("mid_rst_req", 32'(mem_if.imem_req), 32'd0);
    confere("mid_rst_opcode", 32'(opcode), 32'd0);
    reset = 1'b0; PCWrite = 1'b0; Jump = 1'b0;
    #1;
    confere("pos_rst_req", 32'(mem_if.imem_req), 32'd1);
    confere("pos_rst_addr", 32'(mem_if.imem_addr), 32'(PC_INI));
    confere("pos_rst_valida", 32'(instr_valida), 32'd0);
    confere("pos_rst_ir", 32'({opcode, imediato}), 32'd0);
    model_pc = PC_INI;
    executa(8'h25, 1, 1, 1'b0, 1'b0, 1'b0, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_comp, n_erro);
    $finish;
  end

endmodule
